// File: rtl/posit_mac_pkg.sv
// Shared types and widths for the posit MAC scheduler slice.
package posit_mac_pkg;

    localparam int ACT_W       = 16;
    localparam int ACC_W       = 32;
    localparam int EXP_W       = 5;
    localparam int W_W         = 4;
    localparam int PREC_W      = 4;
    localparam int PREC_POSIT4 = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_RESULT
    } state_t;

endpackage

// File: rtl/posit_sched_beat_cnt.sv
// Loadable down-counter that times the per-element mac_valid window.
module posit_sched_beat_cnt
    import posit_mac_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [PREC_W-1:0] load_val,
    output logic              active,
    output logic              last_beat
);

    logic [PREC_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - PREC_W'(1);
        end
    end

    assign active    = (cnt_q != '0);
    assign last_beat = (cnt_q == PREC_W'(1));

endmodule

// File: rtl/posit_mac_scheduler.sv
// Job sequencer in front of one mineMAC; POSIT_SCHED_NAR_ABORT_EN
// enables draining the remaining elements once a NaR is reported.
module posit_mac_scheduler
    import posit_mac_pkg::*;
#(
    parameter int ACT_WIDTH = 16,
    parameter int ACC_WIDTH = 32,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [PREC_W-1:0]    cfg_precision,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    input  logic [EXP_W-1:0]     cfg_exp_min,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ACT_WIDTH-1:0] in_act,
    input  logic [W_W-1:0]       in_w,
    output logic                 mac_valid,
    output logic                 mac_set,
    output logic [PREC_W-1:0]    mac_precision,
    output logic [ACT_WIDTH-1:0] mac_act,
    output logic [W_W-1:0]       mac_w,
    output logic [EXP_W-1:0]     mac_exp_min,
    output logic [ACC_WIDTH-1:0] mac_acc,
    input  logic [EXP_W-1:0]     mac_exp,
    input  logic [ACC_WIDTH-1:0] mac_fxp,
    input  logic                 mac_done,
    input  logic                 mac_nar,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ACC_WIDTH-1:0] res_acc,
    output logic [EXP_W-1:0]     res_exp,
    output logic                 res_nar
);

    state_t state_q, state_d;

    logic [PREC_W-1:0]    prec_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] cnt_q;
    logic [EXP_W-1:0]     exp_min_q;
    logic [EXP_W-1:0]     exp_q;
    logic [ACT_WIDTH-1:0] act_q;
    logic [W_W-1:0]       w_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic                 nar_q;

    logic start_ok;
    logic fetch_hs;
    logic drain_hs;
    logic wait_done;
    logic last_elem;
    logic nar_abort;
    logic beat_active;
    logic last_beat;

    assign start_ok  = (state_q == S_IDLE) && start && (cfg_precision != '0);
    assign fetch_hs  = (state_q == S_FETCH) && in_valid;
    assign drain_hs  = (state_q == S_DRAIN) && in_valid;
    assign wait_done = (state_q == S_WAIT) && mac_done;
    assign last_elem = ((cnt_q + LEN_WIDTH'(1)) == len_q);

`ifdef POSIT_SCHED_NAR_ABORT_EN
    assign nar_abort = mac_nar;
`else
    assign nar_abort = 1'b0;
`endif

    posit_sched_beat_cnt u_beat_cnt (
        .clk       (clk),
        .rst       (rst),
        .load      (fetch_hs),
        .load_val  (prec_q),
        .active    (beat_active),
        .last_beat (last_beat)
    );

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        mac_valid = 1'b0;
        mac_set   = 1'b0;
        res_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_SET;
            end
            S_SET: begin
                mac_set = 1'b1;
                state_d = (len_q == '0) ? S_RESULT : S_FETCH;
            end
            S_FETCH: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                mac_valid = beat_active;
                if (last_beat) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mac_done) begin
                    if (last_elem)      state_d = S_RESULT;
                    else if (nar_abort) state_d = S_DRAIN;
                    else                state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
`ifdef POSIT_SCHED_NAR_ABORT_EN
                in_ready = 1'b1;
                if (in_valid && last_elem) state_d = S_RESULT;
`else
                state_d = S_IDLE;
`endif
            end
            S_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            prec_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            exp_min_q <= '0;
            exp_q     <= '0;
            act_q     <= '0;
            w_q       <= '0;
            acc_q     <= '0;
            nar_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                prec_q    <= cfg_precision;
                len_q     <= cfg_len;
                exp_min_q <= cfg_exp_min;
                exp_q     <= cfg_exp_min;
                cnt_q     <= '0;
                acc_q     <= '0;
                nar_q     <= 1'b0;
            end
            if (fetch_hs) begin
                act_q <= in_act;
                w_q   <= in_w;
            end
            // An aborted job reports a zero accumulator
            if (wait_done) begin
                acc_q <= nar_abort ? '0 : mac_fxp;
                exp_q <= mac_exp;
                nar_q <= nar_q | mac_nar;
                cnt_q <= cnt_q + LEN_WIDTH'(1);
            end
            if (drain_hs) begin
                cnt_q <= cnt_q + LEN_WIDTH'(1);
            end
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign mac_precision = prec_q;
    assign mac_exp_min   = exp_min_q;
    assign mac_act       = act_q;
    assign mac_w         = w_q;
    assign mac_acc       = acc_q;
    assign res_acc       = acc_q;
    assign res_exp       = exp_q;
    assign res_nar       = nar_q;

endmodule

// File: tb/tb_posit_mac_scheduler.sv
// Randomized bench for posit_mac_scheduler with a behavioural MAC and job model;
// expectations follow POSIT_SCHED_NAR_ABORT_EN when it is defined.
module tb_posit_mac_scheduler;
    import posit_mac_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  cfg_precision;
    logic [7:0]  cfg_len;
    logic [4:0]  cfg_exp_min;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_act;
    logic [3:0]  in_w;
    logic        mac_valid;
    logic        mac_set;
    logic [3:0]  mac_precision;
    logic [15:0] mac_act;
    logic [3:0]  mac_w;
    logic [4:0]  mac_exp_min;
    logic [31:0] mac_acc;
    logic [4:0]  mac_exp;
    logic [31:0] mac_fxp;
    logic        mac_done;
    logic        mac_nar;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_acc;
    logic [4:0]  res_exp;
    logic        res_nar;

    posit_mac_scheduler dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_precision(cfg_precision), .cfg_len(cfg_len),
        .cfg_exp_min(cfg_exp_min), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_act(in_act), .in_w(in_w),
        .mac_valid(mac_valid), .mac_set(mac_set),
        .mac_precision(mac_precision), .mac_act(mac_act),
        .mac_w(mac_w), .mac_exp_min(mac_exp_min), .mac_acc(mac_acc),
        .mac_exp(mac_exp), .mac_fxp(mac_fxp),
        .mac_done(mac_done), .mac_nar(mac_nar),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_acc(res_acc), .res_exp(res_exp), .res_nar(res_nar)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    int set_cnt, val_cnt, hs_cnt, win_cnt;
    int cur_prec;
    int nar_at;
    int el_idx;
    int pct;
    int f_n, f_idx;
    bit hs_now;
    logic [15:0] f_act [16];
    logic [3:0]  f_w   [16];
    logic [31:0] seen_acc [$];

    int          mb;
    int          lat;
    logic [15:0] m_act;
    logic [3:0]  m_w;
    logic [31:0] m_acc;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Observation of handshakes and pulses, away from the active edge
    always @(negedge clk) begin
        hs_now = in_valid && in_ready;
        if (rst) begin
            set_cnt += int'(mac_set);
            val_cnt += int'(mac_valid);
            hs_cnt  += int'(hs_now);
        end
    end

    // Element source with randomly toggled in_valid
    always @(posedge clk) begin
        #1;
        if (hs_now) f_idx++;
        if (f_idx < f_n && f_idx < 16) begin
            in_valid = ($urandom_range(0, 99) < pct);
            in_act   = f_act[f_idx];
            in_w     = f_w[f_idx];
        end else begin
            in_valid = 1'b0;
        end
    end

    // Behavioural MAC: result = acc + act*w + 1, done 1..3 cycles after the window
    always @(negedge clk) begin
        mac_done = 1'b0;
        mac_nar  = 1'b0;
        if (!rst) begin
            mb  = 0;
            lat = -1;
        end else if (mac_valid) begin
            if (mb == 0) begin
                m_act = mac_act;
                m_w   = mac_w;
                m_acc = mac_acc;
                seen_acc.push_back(mac_acc);
                win_cnt++;
            end else begin
                chk("mac_in_stable", {12'h0, mac_act, mac_w}, {12'h0, m_act, m_w});
            end
            if (mb == 1 && $urandom_range(0, 1) == 1) begin
                mac_done = 1'b1;
                mac_fxp  = 32'hDEAD_BEEF;
                mac_exp  = 5'h1f;
            end
            mb++;
        end else if (mb > 0) begin
            chk("valid_window_len", mb, cur_prec);
            mb  = 0;
            lat = $urandom_range(0, 2);
        end else if (lat == 0) begin
            mac_done = 1'b1;
            mac_fxp  = m_acc + 32'(m_act) * 32'(m_w) + 32'd1;
            mac_exp  = 5'(m_act[4:0] + 5'(m_w));
            mac_nar  = (el_idx == nar_at);
            el_idx++;
            lat = -1;
        end else if (lat > 0) begin
            lat--;
        end
    end

    task automatic clear_counts();
        set_cnt = 0;
        val_cnt = 0;
        hs_cnt  = 0;
        win_cnt = 0;
        el_idx  = 0;
        seen_acc.delete();
    endtask

    task automatic fill_rand(input bit same);
        for (int i = 0; i < 16; i++) begin
            f_act[i] = same && i > 0 ? f_act[0] : 16'($urandom);
            f_w[i]   = same && i > 0 ? f_w[0]   : 4'($urandom);
        end
    endtask

    task automatic pulse_start(input int len, input int prec, input logic [4:0] emin);
        @(posedge clk); #1;
        start         = 1'b1;
        cfg_len       = 8'(len);
        cfg_precision = 4'(prec);
        cfg_exp_min   = emin;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_job(input int len, input int prec, input logic [4:0] emin,
                           input int nar_idx, input int pct_in, input int delay,
                           input bit busy_start, input bit early_ready);
        logic [31:0] ea;
        logic [4:0]  ee;
        logic        en;
        int          iss;
        bit          ab;
        logic [31:0] pre [$];
        logic [31:0] held;
        int          t;

        ea = 32'd0; ee = emin; en = 1'b0; iss = 0; ab = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (!ab) begin
                pre.push_back(ea);
                iss++;
                ea = ea + 32'(f_act[i]) * 32'(f_w[i]) + 32'd1;
                ee = 5'(f_act[i][4:0] + 5'(f_w[i]));
                if (i == nar_idx) begin
                    en = 1'b1;
`ifdef POSIT_SCHED_NAR_ABORT_EN
                    ab = 1'b1;
                    ea = 32'd0;
`endif
                end
            end
        end

        clear_counts();
        cur_prec  = prec;
        nar_at    = nar_idx;
        pct       = pct_in;
        f_n       = len;
        f_idx     = 0;
        res_ready = early_ready;
        pulse_start(len, prec, emin);

        if (busy_start) begin
            repeat (3) @(negedge clk);
            chk("busy_mid_job", busy, 1);
            pulse_start(1, 5, 5'h1e);
        end

        t = 0;
        while (!res_valid && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("res_valid_seen", res_valid, 1);
        chk("prec_latched", mac_precision, prec);
        chk("exp_min_latched", mac_exp_min, emin);
        chk("res_acc", res_acc, ea);
        chk("res_exp", res_exp, ee);
        chk("res_nar", res_nar, en);
        chk("set_pulses", set_cnt, 1);
        chk("in_handshakes", hs_cnt, len);
        chk("mac_windows", win_cnt, iss);
        chk("valid_cycles", val_cnt, iss * prec);
        for (int i = 0; i < iss; i++)
            if (i < seen_acc.size()) chk("mac_acc_feedback", seen_acc[i], pre[i]);

        if (early_ready) begin
            @(posedge clk); #1;
            res_ready = 1'b0;
        end else begin
            held = res_acc;
            repeat (delay) @(negedge clk);
            chk("res_valid_held", res_valid, 1);
            chk("res_acc_stable", res_acc, held);
            @(posedge clk); #1;
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
        end
        @(negedge clk);
        chk("idle_after_result", busy, 0);
        chk("res_valid_dropped", res_valid, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; cfg_precision = '0; cfg_len = '0;
        cfg_exp_min = '0; in_valid = 1'b0; in_act = '0; in_w = '0;
        res_ready = 1'b0; mac_done = 1'b0; mac_nar = 1'b0;
        mac_fxp = '0; mac_exp = '0;
        pct = 100; f_n = 0; f_idx = 0; nar_at = -1; cur_prec = 0;
        clear_counts();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mac_set", mac_set, 0);
        chk("rst_mac_valid", mac_valid, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_acc", res_acc, 0);
        chk("rst_mac_prec", mac_precision, 0);
        chk("rst_mac_acc", mac_acc, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        f_act[0] = 16'h1234;
        f_w[0]   = 4'b0101;
        run_job(1, PREC_POSIT4, 5'h03, -1, 100, 0, 1'b0, 1'b0);

        fill_rand(1'b1);
        run_job(3, 4, 5'h07, -1, 50, 5, 1'b0, 1'b0);

        run_job(0, 3, 5'h11, -1, 100, 1, 1'b0, 1'b0);

        clear_counts();
        pulse_start(2, 0, 5'h02);
        repeat (3) @(negedge clk);
        chk("prec0_busy", busy, 0);
        chk("prec0_no_set", set_cnt, 0);
        chk("prec0_no_ready", in_ready, 0);

        fill_rand(1'b0);
        run_job(4, 3, 5'h05, -1, 70, 2, 1'b1, 1'b0);

        fill_rand(1'b0);
        run_job(4, 2, 5'h09, 1, 80, 1, 1'b0, 1'b0);

        fill_rand(1'b0);
        clear_counts();
        cur_prec = 4; nar_at = -1; pct = 100; f_n = 2; f_idx = 0;
        pulse_start(2, 4, 5'h04);
        for (int t = 0; t < 200 && !mac_valid; t++) @(negedge clk);
        @(negedge clk);
        chk("beat2_valid", mac_valid, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_mac_valid", mac_valid, 0);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_res_acc", res_acc, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        fill_rand(1'b0);
        run_job(3, 5, 5'h0c, -1, 90, 0, 1'b0, 1'b0);

        for (int j = 0; j < 5; j++) begin
            int l;
            l = $urandom_range(1, 6);
            fill_rand(1'b0);
            run_job(l, $urandom_range(1, 15), 5'($urandom_range(0, 31)),
                    $urandom_range(0, 1) == 1 ? $urandom_range(0, l - 1) : -1,
                    $urandom_range(30, 100), $urandom_range(0, 3),
                    1'b0, j == 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/posit_mac_scheduler.md
Name: posit_mac_scheduler

Overview:
- Sequencer in front of one mineMAC (FP16 activation × posit weight MAC).
- Runs a dot product of cfg_len elements:
  - latches precision into the MAC with a one-cycle set pulse;
  - pulls act/weight pairs from a ready/valid stream;
  - holds mac_valid for the required beats per element;
  - feeds the running accumulator back into the MAC;
  - returns the final accumulator, exponent and NaR flag on a result handshake.

Parameters:
- ACT_WIDTH, 16, activation width (FP16).
- ACC_WIDTH, 32, fixed-point accumulator width.
- LEN_WIDTH, 8, element-count width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- start  in  1  begin job; sampled in IDLE only
- cfg_precision  in  4  posit width = beats per element; 0 is illegal
- cfg_len  in  LEN_WIDTH  element count
- cfg_exp_min  in  5  alignment exponent passed to MAC
- busy  out  1  job in progress (not IDLE)
- in_valid  in  1  element available
- in_ready  out  1  element accepted when in_valid && in_ready
- in_act  in  ACT_WIDTH  FP16 activation
- in_w  in  4  posit weight
- mac_valid  out  1  to MAC valid
- mac_set  out  1  to MAC set
- mac_precision  out  4  to MAC precision
- mac_act  out  ACT_WIDTH  to MAC act
- mac_w  out  4  to MAC w
- mac_exp_min  out  5  to MAC exp_min
- mac_acc  out  ACC_WIDTH  to MAC fixed_point_acc
- mac_exp  in  5  from MAC exp_out
- mac_fxp  in  ACC_WIDTH  from MAC fixed_point_out
- mac_done  in  1  from MAC done
- mac_nar  in  1  from MAC NaR_out
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_acc  out  ACC_WIDTH  final accumulator
- res_exp  out  5  final exponent
- res_nar  out  1  NaR seen during job

Behaviour:
- Reset (rst=0 at posedge):
  - state IDLE; all outputs 0, including res_*; internal acc, count, beat and nar registers cleared.
  - Reset mid-job aborts the job with no result. The MAC shares rst.
- Configuration:
  - cfg_* latched on an accepted start (IDLE && start && cfg_precision!=0).
  - start with cfg_precision==0 is ignored.
  - start in any other state is ignored.
  - mac_precision and mac_exp_min drive the latched values for the whole job.
- FSM:
  - IDLE -> SET on accepted start; acc and nar cleared.
  - SET: mac_set=1 for exactly one cycle. If len==0, go to RESULT with res_acc=0, res_exp=cfg_exp_min, res_nar=0. Otherwise go to FETCH.
  - FETCH: in_ready=1. On handshake, capture act/w into mac_act/mac_w, go to ISSUE.
  - ISSUE: mac_valid=1 for exactly precision consecutive cycles; act/w held stable. Beat counter runs 0..precision-1, then state goes to WAIT.
  - WAIT: mac_valid=0; wait for mac_done. On mac_done, in the same cycle:
    - acc<=mac_fxp;
    - exp<=mac_exp;
    - nar|=mac_nar;
    - count++.
    - If count==len go to RESULT, else go to FETCH.
  - RESULT: res_valid=1 with res_* stable until res_ready. On handshake, go to IDLE.
- mac_done is sampled in WAIT only; any done seen in ISSUE is ignored.
- mac_acc = internal acc register: 0 for the first element, then previous mac_fxp.
- Per-element latency: 1 fetch cycle (min) + precision beats + MAC done latency.
- in_ready is never high outside FETCH; in_valid low in FETCH simply stalls.
- res_ready held high before RESULT has no effect.

Optional Feature:
- Macro: POSIT_SCHED_NAR_ABORT_EN.
- Defined:
  - On mac_nar=1 in WAIT, state goes to DRAIN.
  - DRAIN: in_ready=1; remaining elements are consumed without MAC issue, until count==len.
  - Then RESULT with res_nar=1 and res_acc=0.
- Undefined:
  - No DRAIN state; every element is issued.
  - nar is sticky-OR'd; res_acc is the last mac_fxp.

Decomposition:
- Package posit_mac_pkg holds:
  - state encoding (IDLE, SET, FETCH, ISSUE, WAIT, DRAIN, RESULT);
  - width constants: ACT 16, ACC 32, exp 5, weight 4, precision 4;
  - PREC_POSIT4=4.
- Sub-module posit_sched_beat_cnt: loadable down-counter producing the mac_valid window and last_beat.

Test Plan:
- len=1, precision=4, exp_min=3, act=16'h1234, w=4'b0101, real mineMAC:
  - mac_set is high exactly 1 cycle;
  - mac_valid is high exactly 4 cycles;
  - res_acc=32'h0000_0C68, res_exp=5'h03, res_nar=0.
- len=3, same element repeated, in_valid toggled randomly:
  - exactly 3 in_ready handshakes and 3 mac_valid windows;
  - mac_acc of element n equals res_acc after element n-1;
  - res_valid is held until res_ready is raised 5 cycles late.
- len=0 start:
  - one mac_set pulse, no in_ready, no mac_valid;
  - RESULT with res_acc=0, res_exp=cfg_exp_min.
- start with cfg_precision=0, and start while busy:
  - no state change, no mac_set.
- MAC model asserts mac_nar on element 2 of 4:
  - without the macro: 4 issues, res_nar=1;
  - with the macro: 2 issues, 2 drained handshakes, res_nar=1, res_acc=0.
- rst=0 asserted during ISSUE beat 2:
  - next cycle busy=0, mac_valid=0, res_valid=0;
  - a new job afterwards completes normally.
